// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART frame scheduler and other users
// of the shared transmitter.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_GAP  = 3'd5
  } sched_state_e;

  // Upper nibble of the header byte; the lower nibble carries the requester id.
  localparam logic [3:0] HDR_TAG = 4'hA;

  localparam int CLKS_PER_BIT  = 1736;
  localparam int BITS_PER_BYTE = 10;

  // Shortest legal abort window: one full frame on the wire plus handshake slack.
  localparam int MIN_TIMEOUT = BITS_PER_BYTE * CLKS_PER_BIT + 2;

  // One frame time plus 15 % margin, rounded up to a whole thousand cycles.
  localparam int DEFAULT_TIMEOUT =
    ((BITS_PER_BYTE * CLKS_PER_BIT * 115 / 100 + 999) / 1000) * 1000;

  // Header byte announcing which requester owns the following payload.
  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: the requester right after last_grant
// has the highest priority, wrapping at N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   last_grant,
  output logic [3:0]   grant_idx,
  output logic         any
);

  // Pick the asserted request with the smallest rotated distance from last_grant.
  always_comb begin
    int best_v;
    int dist_v;
    grant_idx = 4'd0;
    any       = 1'b0;
    best_v    = N;
    dist_v    = 0;
    for (int i = 0; i < N; i++) begin
      dist_v = (i + N - int'(last_grant) - 1) % N;
      if (req[i] && (dist_v < best_v)) begin
        best_v    = dist_v;
        grant_idx = 4'(i);
        any       = 1'b1;
      end else begin
        best_v = best_v;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Frame-level round-robin scheduler sharing one UART transmitter between
// NUM_REQ byte-stream requesters, with optional id header and done timeout.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter bit HDR_EN         = 1'b1,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [3:0]             grant_id,
  output logic                   tx_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  // cnt_r holds cycles elapsed since tx_start; the abort is decided on the
  // cycle where the count would step to TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  sched_state_e         state_r;
  logic                 tx_start_r;
  logic [7:0]           tx_data_r;
  logic [NUM_REQ-1:0]   req_ready_r;
  logic                 busy_r;
  logic [3:0]           grant_id_r;
  logic                 tx_err_r;
  logic [3:0]           last_grant_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 hdr_phase_r;
  logic                 last_r;
  logic                 abort_r;

  logic [3:0]           arb_idx_s;
  logic                 arb_any_s;
  logic                 sel_valid_s;
  logic                 sel_last_s;
  logic [7:0]           sel_data_s;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant_idx  (arb_idx_s),
    .any        (arb_any_s)
  );

  // One-hot ready mask for the granted requester.
  function automatic logic [NUM_REQ-1:0] grant_mask(input logic [3:0] idx);
    logic [NUM_REQ-1:0] m;
    m = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == 4'(i)) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Route the granted requester's valid/last/data to the sequencer.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_r == 4'(i)) begin
        sel_valid_s = req_valid[i];
        sel_last_s  = req_last[i];
        sel_data_s  = req_data[8*i +: 8];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Frame sequencer: arbitration, header, byte handshake, timeout and gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      req_ready_r  <= {NUM_REQ{1'b0}};
      busy_r       <= 1'b0;
      grant_id_r   <= 4'd0;
      tx_err_r     <= 1'b0;
      last_grant_r <= 4'(NUM_REQ - 1);
      cnt_r        <= {CNT_W{1'b0}};
      hdr_phase_r  <= 1'b0;
      last_r       <= 1'b0;
      abort_r      <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      tx_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (arb_any_s) begin
            grant_id_r <= arb_idx_s;
            busy_r     <= 1'b1;
            if (HDR_EN) begin
              state_r <= ST_HDR;
            end else begin
              state_r     <= ST_LOAD;
              req_ready_r <= grant_mask(arb_idx_s);
            end
          end
        end
        ST_HDR: begin
          tx_data_r   <= hdr_byte(grant_id_r);
          hdr_phase_r <= 1'b1;
          tx_start_r  <= 1'b1;
          state_r     <= ST_SEND;
        end
        ST_LOAD: begin
          // Grant is held with no timeout until the requester offers a byte.
          if (sel_valid_s) begin
            tx_data_r   <= sel_data_s;
            last_r      <= sel_last_s;
            req_ready_r <= {NUM_REQ{1'b0}};
            tx_start_r  <= 1'b1;
            state_r     <= ST_SEND;
          end
        end
        ST_SEND: begin
          cnt_r   <= CNT_W'(1);
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // done takes precedence over a timeout landing on the same cycle
          if (tx_done) begin
            state_r <= ST_GAP;
          end else if (cnt_r == TO_LAST) begin
            tx_err_r <= 1'b1;
            abort_r  <= 1'b1;
            state_r  <= ST_GAP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_GAP: begin
          // Wait out a multi-cycle done before the next start.
          if (!tx_done) begin
            if (hdr_phase_r) begin
              hdr_phase_r <= 1'b0;
              req_ready_r <= grant_mask(grant_id_r);
              state_r     <= ST_LOAD;
            end else if (last_r || abort_r) begin
              last_grant_r <= grant_id_r;
              abort_r      <= 1'b0;
              busy_r       <= 1'b0;
              state_r      <= ST_IDLE;
            end else begin
              req_ready_r <= grant_mask(grant_id_r);
              state_r     <= ST_LOAD;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          req_ready_r <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;
  assign busy      = busy_r;
  assign grant_id  = grant_id_r;
  assign tx_err    = tx_err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester and transmitter models,
// expected {grant,byte} queue checked by a monitor on every tx_start.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [3:0]  grant_id;
  logic        tx_err;

  uart_tx_scheduler #(
    .NUM_REQ        (4),
    .HDR_EN         (1'b1),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .tx_err    (tx_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;
  int n_start = 0;
  int since_start = 0;

  logic [10:0] rq[$];     // {id[1:0], last, data}
  logic [11:0] exp_q[$];  // {grant[3:0], data}
  int          err_q[$];  // expected cycles from tx_start to tx_err

  int done_delay = 3;
  int done_len   = 2;
  int dead_byte  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_req(input int id, input logic [7:0] d, input logic last);
    rq.push_back({2'(id), last, d});
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  function automatic int find_head(input int id);
    for (int j = 0; j < rq.size(); j++)
      if (int'(rq[j][10:9]) == id) return j;
    return -1;
  endfunction

  // Requester model: present queue heads, pop on valid&ready.
  initial begin
    logic [3:0] xfer;
    xfer = 4'b0000;
    req_valid = 4'b0000; req_data = 32'h0; req_last = 4'b0000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        int j;
        if (xfer[i]) begin
          j = find_head(i);
          if (j >= 0) rq.delete(j);
        end
      end
      for (int i = 0; i < 4; i++) begin
        int j;
        j = find_head(i);
        if (j >= 0) begin
          req_valid[i] = 1'b1; req_last[i] = rq[j][8]; req_data[8*i +: 8] = rq[j][7:0];
        end else begin
          req_valid[i] = 1'b0; req_last[i] = 1'b0; req_data[8*i +: 8] = 8'h00;
        end
      end
      xfer = req_valid & req_ready;
    end
  end

  // Transmitter model: done after done_delay cycles for done_len cycles.
  initial begin
    int dcnt;
    int hcnt;
    dcnt = -1; hcnt = 0; tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_done = 1'b0; dcnt = -1; hcnt = 0;
      end else begin
        if (hcnt > 0) begin
          hcnt--;
          if (hcnt == 0) tx_done = 1'b0;
        end
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) begin tx_done = 1'b1; hcnt = done_len; dcnt = -1; end
        end
        if (tx_start && int'(tx_data) != dead_byte) dcnt = done_delay;
      end
    end
  end

  // Monitor: compare every started byte and every error pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) since_start = 0;
      else since_start++;
      if (tx_start) begin
        n_start++;
        check("start_while_done", {31'd0, tx_done}, 32'd0);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_start: got data %0h grant %0h expected none", tx_data, grant_id);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
          check("grant_id", {28'd0, grant_id}, {28'd0, e[11:8]});
        end
      end
      if (tx_err) begin
        if (err_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_tx_err: got pulse at %0d cycles expected none", since_start);
        end else begin
          int e;
          e = err_q.pop_front();
          check("err_delay", since_start, e);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((rq.size() != 0 || exp_q.size() != 0 || busy) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_drained"}, {31'd0, (cyc < 3000)}, 32'd1);
    check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({name, "_err_left"}, err_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    check({name, "_tx_data"}, {24'd0, tx_data}, 32'h00);
    check({name, "_req_ready"}, {28'd0, req_ready}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_grant_id"}, {28'd0, grant_id}, 32'd0);
    check({name, "_tx_err"}, {31'd0, tx_err}, 32'd0);
  endtask

  initial begin
    int s0;
    int cyc;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Header plus two-byte frame from requester 0.
    s0 = n_start;
    push_req(0, 8'h11, 1'b0); push_req(0, 8'h22, 1'b1);
    push_exp(4'd0, 8'hA0); push_exp(4'd0, 8'h11); push_exp(4'd0, 8'h22);
    wait_idle("t1");
    check("t1_start_count", n_start - s0, 32'd3);

    // Round robin between requesters 1 and 3.
    push_req(1, 8'h31, 1'b1); push_req(3, 8'h33, 1'b1);
    push_exp(4'd1, 8'hA1); push_exp(4'd1, 8'h31);
    push_exp(4'd3, 8'hA3); push_exp(4'd3, 8'h33);
    wait_idle("t2a");
    push_req(1, 8'h31, 1'b1); push_req(1, 8'h41, 1'b1);
    push_req(3, 8'h33, 1'b1); push_req(3, 8'h43, 1'b1);
    push_exp(4'd1, 8'hA1); push_exp(4'd1, 8'h31);
    push_exp(4'd3, 8'hA3); push_exp(4'd3, 8'h33);
    push_exp(4'd1, 8'hA1); push_exp(4'd1, 8'h41);
    push_exp(4'd3, 8'hA3); push_exp(4'd3, 8'h43);
    wait_idle("t2b");

    // Frame atomicity: req0 arrives mid-frame of req2.
    push_req(2, 8'h51, 1'b0); push_req(2, 8'h52, 1'b0); push_req(2, 8'h53, 1'b1);
    push_exp(4'd2, 8'hA2); push_exp(4'd2, 8'h51); push_exp(4'd2, 8'h52); push_exp(4'd2, 8'h53);
    repeat (10) @(negedge clk);
    check("t3_midframe_busy", {31'd0, busy}, 32'd1);
    push_req(0, 8'h61, 1'b1);
    push_exp(4'd0, 8'hA0); push_exp(4'd0, 8'h61);
    wait_idle("t3");

    // Timeout on byte 71 aborts req1's frame; req3 goes next, then req1's rest.
    dead_byte = 32'h71;
    push_req(1, 8'h71, 1'b0); push_req(1, 8'h72, 1'b1); push_req(3, 8'h73, 1'b1);
    push_exp(4'd1, 8'hA1); push_exp(4'd1, 8'h71); err_q.push_back(49);
    push_exp(4'd3, 8'hA3); push_exp(4'd3, 8'h73);
    push_exp(4'd1, 8'hA1); push_exp(4'd1, 8'h72);
    wait_idle("t4");
    dead_byte = -1;

    // done lands on the exact timeout cycle: no error.
    done_delay = 48;
    push_req(0, 8'h81, 1'b0); push_req(0, 8'h82, 1'b1);
    push_exp(4'd0, 8'hA0); push_exp(4'd0, 8'h81); push_exp(4'd0, 8'h82);
    wait_idle("t5");

    // Reset during WAIT of payload byte 91.
    done_delay = 30;
    push_req(2, 8'h91, 1'b0); push_req(2, 8'h92, 1'b1);
    push_exp(4'd2, 8'hA2); push_exp(4'd2, 8'h91);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 500) begin @(negedge clk); cyc++; end
    check("t6_reached_wait", {31'd0, (cyc < 500)}, 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    done_delay = 3;
    push_req(0, 8'h95, 1'b1);
    push_exp(4'd0, 8'hA0); push_exp(4'd0, 8'h95);
    push_exp(4'd2, 8'hA2); push_exp(4'd2, 8'h92);
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    wait_idle("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
